// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS memory stage.
// Provides the Size_MEM encodings, the memory-access FSM state type and an
// alignment helper used by the lane aligner.
package mips_pkg;

    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } mem_state_t;

    // Size 11 is handled as a word, so it shares the word alignment rule.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] off);
        case (size)
            SIZE_BYTE: is_misaligned = 1'b0;
            SIZE_HALF: is_misaligned = off[0];
            default:   is_misaligned = (off != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory bus.
// Store side: st_size_i / st_off_i / st_data_i -> byte_en_o, wdata_o
//             (data replicated across lanes), misaligned_o.
// Load side:  ld_size_i / ld_off_i / rdata_i -> ldata_o (lane extracted,
//             sign-extended). Lane 0 is bits 7:0 (little-endian).
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  st_size_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  byte_en_o,
    output logic [31:0] wdata_o,
    output logic        misaligned_o,
    input  logic [1:0]  ld_size_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] ldata_o
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        byte_en_o = 4'b1111;
        wdata_o   = st_data_i;
        case (st_size_i)
            SIZE_BYTE: begin
                byte_en_o = 4'b0001 << st_off_i;
                wdata_o   = {4{st_data_i[7:0]}};
            end
            SIZE_HALF: begin
                byte_en_o = st_off_i[1] ? 4'b1100 : 4'b0011;
                wdata_o   = {2{st_data_i[15:0]}};
            end
            default: begin
                byte_en_o = 4'b1111;
                wdata_o   = st_data_i;
            end
        endcase
        misaligned_o = is_misaligned(st_size_i, st_off_i);
    end

    always_comb begin
        ld_byte = rdata_i[{ld_off_i, 3'b000} +: 8];
        ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (ld_size_i)
            SIZE_BYTE: ldata_o = {{24{ld_byte[7]}}, ld_byte};
            SIZE_HALF: ldata_o = {{16{ld_half[15]}}, ld_half};
            default:   ldata_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit. Turns the EX/MEM request into a req/ack
// transaction on a word-wide data bus and stalls the pipeline until done.
// Pipeline side: MemRead_MEM, MemWrite_MEM, Size_MEM, ALUResult_MEM (address),
//                ReadData2_MEM (store data) in; Stall (combinational),
//                LoadData_MEM, AddrError, BusError (registered) out.
// Bus side:      MemReq, MemWe, MemAddr, MemByteEn, MemWData (registered) out;
//                MemRData, MemAck in (MemAck only sampled in REQ).
module mem_access_unit
    import mips_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter int unsigned CNT_W          = 5
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        MemRead_MEM,
    input  logic        MemWrite_MEM,
    input  logic [1:0]  Size_MEM,
    input  logic [31:0] ALUResult_MEM,
    input  logic [31:0] ReadData2_MEM,
    output logic        Stall,
    output logic [31:0] LoadData_MEM,
    output logic        AddrError,
    output logic        BusError,
    output logic        MemReq,
    output logic        MemWe,
    output logic [31:0] MemAddr,
    output logic [3:0]  MemByteEn,
    output logic [31:0] MemWData,
    input  logic [31:0] MemRData,
    input  logic        MemAck
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    mem_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        size_q, size_d;
    logic [1:0]        off_q, off_d;
    logic [31:0]       load_q, load_d;
    logic              aerr_q, aerr_d;
    logic              berr_q, berr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              access;
    logic              misaligned;
    logic [3:0]        be_new;
    logic [31:0]       wdata_new;
    logic [31:0]       ldata;

    assign access = MemRead_MEM | MemWrite_MEM;

    // Store path works on the live EX/MEM inputs; load path uses the size and
    // offset captured at issue so extraction does not depend on EX/MEM holding.
    mem_lane_align u_align (
        .st_size_i    (Size_MEM),
        .st_off_i     (ALUResult_MEM[1:0]),
        .st_data_i    (ReadData2_MEM),
        .byte_en_o    (be_new),
        .wdata_o      (wdata_new),
        .misaligned_o (misaligned),
        .ld_size_i    (size_q),
        .ld_off_i     (off_q),
        .rdata_i      (MemRData),
        .ldata_o      (ldata)
    );

    assign Stall = !Reset && (((state_q == IDLE) && access) || (state_q == REQ));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        size_d  = size_q;
        off_d   = off_q;
        load_d  = load_q;
        aerr_d  = aerr_q;
        berr_d  = berr_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (access) begin
                    if (misaligned) begin
                        state_d = DONE;
                        aerr_d  = 1'b1;
                        load_d  = '0;
                    end else begin
                        state_d = REQ;
                        req_d   = 1'b1;
                        // Write wins when both strobes are set.
                        we_d    = MemWrite_MEM;
                        addr_d  = {ALUResult_MEM[31:2], 2'b00};
                        be_d    = be_new;
                        wdata_d = wdata_new;
                        size_d  = Size_MEM;
                        off_d   = ALUResult_MEM[1:0];
                        cnt_d   = '0;
                    end
                end
            end
            REQ: begin
                if (MemAck) begin
                    if (!we_q) begin
                        load_d = ldata;
                    end
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (cnt_q == CNT_LAST) begin
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    load_d  = '0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                aerr_d  = 1'b0;
                berr_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            size_q  <= '0;
            off_q   <= '0;
            load_q  <= '0;
            aerr_q  <= 1'b0;
            berr_q  <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            size_q  <= size_d;
            off_q   <= off_d;
            load_q  <= load_d;
            aerr_q  <= aerr_d;
            berr_q  <= berr_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
        end
    end

    assign LoadData_MEM = load_q;
    assign AddrError    = aerr_q;
    assign BusError     = berr_q;
    assign MemReq       = req_q;
    assign MemWe        = we_q;
    assign MemAddr      = addr_q;
    assign MemByteEn    = be_q;
    assign MemWData     = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct {
        logic [31:0] load;
        logic        aerr;
        logic        berr;
        int unsigned stall_cyc;
        int unsigned req_cyc;
    } done_exp_t;

    typedef struct {
        bit          noack;
        int unsigned d;
        logic [31:0] rdata;
    } resp_t;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        MemRead_MEM = 1'b0;
    logic        MemWrite_MEM = 1'b0;
    logic [1:0]  Size_MEM = 2'b00;
    logic [31:0] ALUResult_MEM = '0;
    logic [31:0] ReadData2_MEM = '0;
    logic        Stall;
    logic [31:0] LoadData_MEM;
    logic        AddrError;
    logic        BusError;
    logic        MemReq;
    logic        MemWe;
    logic [31:0] MemAddr;
    logic [3:0]  MemByteEn;
    logic [31:0] MemWData;
    logic [31:0] MemRData = '0;
    logic        MemAck = 1'b0;

    mem_access_unit #(.TIMEOUT_CYCLES(16), .CNT_W(5)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .MemRead_MEM   (MemRead_MEM),
        .MemWrite_MEM  (MemWrite_MEM),
        .Size_MEM      (Size_MEM),
        .ALUResult_MEM (ALUResult_MEM),
        .ReadData2_MEM (ReadData2_MEM),
        .Stall         (Stall),
        .LoadData_MEM  (LoadData_MEM),
        .AddrError     (AddrError),
        .BusError      (BusError),
        .MemReq        (MemReq),
        .MemWe         (MemWe),
        .MemAddr       (MemAddr),
        .MemByteEn     (MemByteEn),
        .MemWData      (MemWData),
        .MemRData      (MemRData),
        .MemAck        (MemAck)
    );

    always #5 Clk = ~Clk;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    bit          mon_en   = 1'b0;
    logic [31:0] model_ld = '0;

    bus_exp_t  bus_q[$];
    done_exp_t done_q[$];
    resp_t     resp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic bit ref_misaligned(input logic [1:0] size, input logic [31:0] addr);
        int unsigned off = addr % 4;
        if (size == 2'd2) return 1'b0;
        if (size == 2'd1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [3:0] ref_be(input logic [1:0] size, input logic [31:0] addr);
        int unsigned off = addr % 4;
        if (size == 2'd2) return 4'(1 << off);
        if (size == 2'd1) return (off >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'd2) return (d % 256) * 32'h0101_0101;
        if (size == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input logic [31:0] addr,
                                             input logic [31:0] rd);
        int unsigned off = addr % 4;
        int v;
        if (size == 2'd2) begin
            v = int'((rd >> (8 * off)) % 256);
            if (v >= 128) v = v - 256;
            return 32'(v);
        end
        if (size == 2'd1) begin
            v = int'((rd >> ((off >= 2) ? 16 : 0)) % 65536);
            if (v >= 32768) v = v - 65536;
            return 32'(v);
        end
        return rd;
    endfunction

    // ---------------- bus responder ----------------
    initial begin : responder
        bit          active = 1'b0;
        int unsigned k = 0;
        resp_t       cur;
        cur = '{noack: 1'b1, d: 0, rdata: '0};
        forever begin
            @(posedge Clk);
            #1;
            if (MemReq) begin
                if (!active) begin
                    active = 1'b1;
                    k = 0;
                    if (resp_q.size() == 0) begin
                        check("resp_queue_empty", 32'd1, 32'd0);
                        cur = '{noack: 1'b1, d: 0, rdata: '0};
                    end else begin
                        cur = resp_q.pop_front();
                    end
                end else begin
                    k++;
                end
                MemAck   = !cur.noack && (k == cur.d);
                MemRData = MemAck ? cur.rdata : $urandom;
            end else begin
                active   = 1'b0;
                // Acks outside a request must be ignored by the unit.
                MemAck   = 1'($urandom_range(0, 1));
                MemRData = $urandom;
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin : monitor
        bit          prev_stall = 1'b0;
        bit          prev_req = 1'b0;
        bit          chk_clear = 1'b0;
        int unsigned stall_cnt = 0;
        int unsigned req_cnt = 0;
        bus_exp_t    cb;
        done_exp_t   de;
        cb = '{we: 1'b0, addr: '0, be: '0, wdata: '0};
        forever begin
            @(negedge Clk);
            if (!mon_en) begin
                prev_stall = 1'b0; prev_req = 1'b0; chk_clear = 1'b0;
                stall_cnt = 0; req_cnt = 0;
                continue;
            end
            if (chk_clear) begin
                check("err_pulse_cleared", {30'd0, AddrError, BusError}, 32'd0);
                chk_clear = 1'b0;
            end
            if (MemReq && !prev_req) begin
                if (bus_q.size() == 0) check("unexpected_req", 32'd1, 32'd0);
                else cb = bus_q.pop_front();
                check("MemWe", {31'd0, MemWe}, {31'd0, cb.we});
                check("MemAddr", MemAddr, cb.addr);
                check("MemByteEn", {28'd0, MemByteEn}, {28'd0, cb.be});
                check("MemWData", MemWData, cb.wdata);
            end else if (MemReq) begin
                check("bus_hold", {MemWe, MemByteEn, MemAddr[26:0]} ^ MemWData,
                      {cb.we, cb.be, cb.addr[26:0]} ^ cb.wdata);
            end
            if (MemReq) req_cnt++;
            if (Stall) stall_cnt++;
            if (prev_stall && !Stall) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    de = done_q.pop_front();
                    check("LoadData_MEM", LoadData_MEM, de.load);
                    check("AddrError", {31'd0, AddrError}, {31'd0, de.aerr});
                    check("BusError", {31'd0, BusError}, {31'd0, de.berr});
                    check("stall_cycles", stall_cnt, de.stall_cyc);
                    check("req_cycles", req_cnt, de.req_cyc);
                end
                stall_cnt = 0;
                req_cnt   = 0;
                chk_clear = 1'b1;
            end
            prev_stall = Stall;
            prev_req   = MemReq;
        end
    end

    // ---------------- driver ----------------
    task automatic issue(input bit rd, input bit wr, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] data,
                         input bit noack, input int unsigned d, input logic [31:0] rdata);
        int unsigned cyc = 0;
        @(posedge Clk);
        #1;
        MemRead_MEM   = rd;
        MemWrite_MEM  = wr;
        Size_MEM      = size;
        ALUResult_MEM = addr;
        ReadData2_MEM = data;
        if (ref_misaligned(size, addr)) begin
            model_ld = '0;
            done_q.push_back('{load: '0, aerr: 1'b1, berr: 1'b0, stall_cyc: 1, req_cyc: 0});
        end else begin
            bus_q.push_back('{we: wr, addr: addr & 32'hFFFF_FFFC, be: ref_be(size, addr),
                              wdata: ref_wdata(size, data)});
            resp_q.push_back('{noack: noack, d: d, rdata: rdata});
            if (noack) begin
                model_ld = '0;
                done_q.push_back('{load: '0, aerr: 1'b0, berr: 1'b1, stall_cyc: 17, req_cyc: 16});
            end else begin
                if (!wr) model_ld = ref_load(size, addr, rdata);
                done_q.push_back('{load: model_ld, aerr: 1'b0, berr: 1'b0,
                                   stall_cyc: d + 2, req_cyc: d + 1});
            end
        end
        do begin
            @(posedge Clk);
            #1;
            cyc++;
        end while (Stall && cyc < 40);
        if (Stall) begin
            check("stall_release_timeout", 32'd1, 32'd0);
            $display("%0d/%0d checks passed", n_pass, n_checks);
            $fatal(1, "FAIL unit never released Stall");
        end
    endtask

    task automatic idle_gap(input int unsigned n);
        repeat (n) begin
            @(posedge Clk);
            #1;
            MemRead_MEM  = 1'b0;
            MemWrite_MEM = 1'b0;
            #1;
            check("no_access_stall", {31'd0, Stall}, 32'd0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "FAIL simulation time limit");
    end

    initial begin : main
        logic [1:0]  sz;
        logic [31:0] a;
        int unsigned op;
        int unsigned cyc;

        // Reset with a pending load: Stall must stay low, everything zero.
        MemRead_MEM = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("rst_stall", {31'd0, Stall}, 32'd0);
        check("rst_req", {31'd0, MemReq}, 32'd0);
        check("rst_load", LoadData_MEM, 32'd0);
        check("rst_errs", {30'd0, AddrError, BusError}, 32'd0);
        check("rst_bus", MemAddr | MemWData | {28'd0, MemByteEn} | {31'd0, MemWe}, 32'd0);
        MemRead_MEM = 1'b0;
        Reset = 1'b0;
        mon_en = 1'b1;
        idle_gap(2);

        // Directed cases.
        issue(1, 0, 2'b00, 32'h0000_1004, 32'h0, 0, 0, 32'hDEAD_BEEF);
        issue(0, 1, 2'b10, 32'h0000_2003, 32'h0000_00A5, 0, 1, 32'h1234_5678);
        issue(1, 0, 2'b01, 32'h0000_3002, 32'h0, 0, 0, 32'h8001_7FFF);
        issue(1, 0, 2'b10, 32'h0000_3001, 32'h0, 0, 2, 32'h0000_7F00);
        issue(1, 0, 2'b00, 32'h0000_4002, 32'h0, 0, 0, 32'h0);
        issue(1, 0, 2'b00, 32'h0000_5000, 32'h0, 1, 0, 32'h0);
        issue(1, 1, 2'b11, 32'h0000_6008, 32'hCAFE_F00D, 0, 0, 32'hFFFF_FFFF);
        idle_gap(1);

        // Randomised traffic.
        for (int i = 0; i < 200; i++) begin
            op = $urandom_range(0, 3);
            sz = 2'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                else if (sz != 2'b10) a[1:0] = 2'b00;
            end
            issue(op == 0 || op == 2 || op == 3, op == 1 || op == 2, sz, a, $urandom,
                  $urandom_range(0, 15) == 0, $urandom_range(0, 4), $urandom);
            idle_gap($urandom_range(0, 2));
        end
        idle_gap(3);
        check("done_queue_drained", done_q.size(), 32'd0);
        check("bus_queue_drained", bus_q.size(), 32'd0);
        mon_en = 1'b0;

        // Reset during the third REQ cycle of an unacknowledged load.
        resp_q.push_back('{noack: 1'b1, d: 0, rdata: '0});
        @(posedge Clk);
        #1;
        MemRead_MEM   = 1'b1;
        MemWrite_MEM  = 1'b0;
        Size_MEM      = 2'b00;
        ALUResult_MEM = 32'h0000_7000;
        cyc = 0;
        do begin
            @(posedge Clk);
            #1;
            cyc++;
        end while (!MemReq && cyc < 10);
        check("rstq_req_seen", {31'd0, MemReq}, 32'd1);
        repeat (2) begin
            @(posedge Clk);
            #1;
        end
        Reset = 1'b1;
        #1;
        check("rstq_stall_in_reset", {31'd0, Stall}, 32'd0);
        @(posedge Clk);
        #1;
        check("rstq_req_dropped", {31'd0, MemReq}, 32'd0);
        check("rstq_no_err_pulse", {30'd0, AddrError, BusError}, 32'd0);
        check("rstq_stall_hold", {31'd0, Stall}, 32'd0);
        @(posedge Clk);
        #1;
        check("rstq_no_late_pulse", {30'd0, AddrError, BusError}, 32'd0);
        MemRead_MEM = 1'b0;
        Reset = 1'b0;
        repeat (2) @(posedge Clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs: Size_MEM, MemRead_MEM, MemWrite_MEM, ALUResult_MEM (address) and ReadData2_MEM (store data).
- Runs each load/store as a req/ack transaction on a word-wide data-memory bus.
- Applies byte lanes and sign-extends load data.
- Holds the pipeline through Stall until the access completes, then presents LoadData_MEM for the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16, REQ cycles without MemAck before the access is abandoned with BusError.
- CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- Clk  in  1  clock; all state changes on posedge Clk.
- Reset  in  1  synchronous, active-high reset; forces all state and registered outputs to 0.
- MemRead_MEM  in  1  load request, from the EX/MEM register.
- MemWrite_MEM  in  1  store request, from the EX/MEM register.
- Size_MEM  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- ALUResult_MEM  in  32  byte address.
- ReadData2_MEM  in  32  store data, right-justified.
- Stall  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM while high.
- LoadData_MEM  out  32  registered, sign-extended load result.
- AddrError  out  1  registered; one-cycle pulse on a misaligned access.
- BusError  out  1  registered; one-cycle pulse on a timeout.
- MemReq  out  1  registered bus request.
- MemWe  out  1  registered; 1 = write.
- MemAddr  out  32  registered; {ALUResult_MEM[31:2], 2'b00}.
- MemByteEn  out  4  registered lane enables; lane 0 = bits 7:0 (little-endian).
- MemWData  out  32  registered store data, replicated across lanes.
- MemRData  in  32  bus read data; valid when MemAck = 1.
- MemAck  in  1  bus completion; sampled only in REQ.

Behaviour:
- Interface: one clock (Clk); reset (Reset) is synchronous and active-high.
- Reset values: all registered outputs 0, state IDLE, counter 0. Stall is forced to 0 while Reset = 1. Reset in any state drops MemReq at the next edge with no completion pulse.
- States: IDLE, REQ, DONE.

IDLE:
- access = MemRead_MEM | MemWrite_MEM. If both are 1, the write wins and no read is performed.
- Misaligned access: half with addr[0] = 1, or word/11 with addr[1:0] != 0.
  - Next state DONE with AddrError = 1.
  - No bus request is issued; LoadData_MEM is cleared to 0.
- Aligned access: next state REQ.
  - Register MemReq = 1, MemWe, MemAddr, MemByteEn, MemWData; counter = 0.
- MemByteEn by size:
  - byte: 1 << addr[1:0].
  - half: addr[1] ? 1100 : 0011.
  - word: 1111.
- MemWData by size:
  - byte: data[7:0] replicated x4.
  - half: data[15:0] replicated x2.
  - word: data as-is.

REQ:
- MemReq, MemWe, MemAddr, MemByteEn and MemWData hold stable.
- MemAck = 1:
  - For a read, LoadData_MEM <= lane-extracted MemRData, sign-extended (byte from lane addr[1:0], half from the half selected by addr[1]).
  - A write leaves LoadData_MEM unchanged.
  - MemReq <= 0; next state DONE.
- MemAck = 0 and counter = TIMEOUT_CYCLES-1: MemReq <= 0, BusError <= 1, LoadData_MEM <= 0, next state DONE.
- Otherwise the counter increments.

DONE:
- Stall = 0, so the pipeline advances at this edge.
- AddrError and BusError are cleared at the next edge.
- Next state is always IDLE. The unit never re-issues the access still held in EX/MEM during DONE.

Stall and latency:
- Stall = !Reset & ((IDLE & access) | REQ).
- Aligned access acked in the first REQ cycle: 3 cycles total, Stall high for 2.
- Misaligned access: 2 cycles.
- No access: Stall = 0 and state stays IDLE.
- MemAck outside REQ is ignored.

Decomposition:
- Shared package (mips_pkg):
  - SIZE_WORD = 2'b00, SIZE_HALF = 2'b01, SIZE_BYTE = 2'b10.
  - Enum mem_state_t {IDLE, REQ, DONE}.
- One combinational sub-module, mem_lane_align: size plus addr[1:0] plus store data in, byte enables and replicated write data out. The same block provides the load extract and sign-extend path.
- The FSM and timeout counter stay in mem_access_unit.

Test Plan:
- LW at 0x0000_1004, MemAck one cycle after MemReq, MemRData = 0xDEADBEEF:
  - MemAddr = 0x1004, MemByteEn = 1111, Stall high for 2 cycles.
  - LoadData_MEM = 0xDEADBEEF in DONE.
- SB at 0x0000_2003 with data 0x000000A5: MemWe = 1, MemByteEn = 1000, MemWData = 0xA5A5A5A5; LoadData_MEM unchanged.
- LH at 0x0000_3002 with MemRData = 0x8001_7FFF: LoadData_MEM = 0xFFFF8001. LB at 0x3001 with MemRData = 0x00007F00: LoadData_MEM = 0x0000007F.
- LW at 0x0000_4002: no MemReq, AddrError pulses one cycle, Stall high for 1 cycle, LoadData_MEM = 0.
- LW with MemAck never asserted, TIMEOUT_CYCLES = 16: MemReq high for exactly 16 cycles, then BusError pulses, LoadData_MEM = 0, state returns to IDLE.
- Reset asserted in the 3rd REQ cycle: MemReq = 0 at the next edge, no AddrError/BusError pulse, Stall = 0 while Reset is high.
